// File: rtl/wav_pkg.sv
// Shared constants, types and helpers for the WAV stream reader.
// Tags are little-endian words so byte lane n of a word is stream byte n.
package wav_pkg;

    localparam int WAV_HDR_BYTES = 44;

    localparam logic [5:0] OFF_RIFF    = 6'd0;
    localparam logic [5:0] OFF_WAVE    = 6'd8;
    localparam logic [5:0] OFF_FMT     = 6'd12;
    localparam logic [5:0] OFF_FMT_LEN = 6'd16;
    localparam logic [5:0] OFF_FMT_PCM = 6'd20;
    localparam logic [5:0] OFF_RATE    = 6'd24;
    localparam logic [5:0] OFF_BLOCK   = 6'd32;
    localparam logic [5:0] OFF_DATA    = 6'd36;
    localparam logic [5:0] OFF_SIZE    = 6'd40;

    localparam logic [31:0] TAG_RIFF = 32'h4646_4952;
    localparam logic [31:0] TAG_WAVE = 32'h4556_4157;
    localparam logic [31:0] TAG_FMT  = 32'h2074_6D66;
    localparam logic [31:0] TAG_DATA = 32'h6174_6164;

    localparam logic [31:0] FMT_CHUNK_LEN = 32'd16;
    localparam logic [15:0] FMT_PCM       = 16'd1;
    localparam logic [15:0] FMT_CHANNELS  = 16'd2;
    localparam logic [15:0] FMT_BITS      = 16'd16;

    typedef enum logic [2:0] {
        ERR_NONE   = 3'd0,
        ERR_RIFF   = 3'd1,
        ERR_WAVE   = 3'd2,
        ERR_FMT    = 3'd3,
        ERR_FORMAT = 3'd4,
        ERR_DATA   = 3'd5
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    typedef struct packed {
        logic      chk;
        err_code_e code;
        logic [7:0] val;
    } hdr_exp_t;

    // Expected header byte at a given index; chk = 0 marks don't-care bytes.
    function automatic hdr_exp_t hdr_expect(input logic [5:0] idx);
        hdr_exp_t   r;
        logic [31:0] w;
        r.chk  = 1'b1;
        r.code = ERR_NONE;
        w      = 32'd0;
        case (idx[5:2])
            OFF_RIFF[5:2]:    begin r.code = ERR_RIFF;   w = TAG_RIFF; end
            OFF_WAVE[5:2]:    begin r.code = ERR_WAVE;   w = TAG_WAVE; end
            OFF_FMT[5:2]:     begin r.code = ERR_FMT;    w = TAG_FMT;  end
            OFF_FMT_LEN[5:2]: begin r.code = ERR_FORMAT; w = FMT_CHUNK_LEN; end
            OFF_FMT_PCM[5:2]: begin r.code = ERR_FORMAT; w = {FMT_CHANNELS, FMT_PCM}; end
            // Block-align lanes are ignored; only bits-per-sample is checked.
            OFF_BLOCK[5:2]:   begin r.chk = idx[1]; r.code = ERR_FORMAT; w = {FMT_BITS, 16'h0000}; end
            OFF_DATA[5:2]:    begin r.code = ERR_DATA;   w = TAG_DATA; end
            default:          begin r.chk = 1'b0; end
        endcase
        r.val = w[{idx[1:0], 3'b000} +: 8];
        return r;
    endfunction

    function automatic logic [23:0] conv_sample(input logic [15:0] s, input int fmt);
        logic [23:0] r;
        if (fmt == 1) begin
            r = {{8{s[15]}}, s};
        end else begin
            r = {8'h00, ~s[15], s[14:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/wav_frame_unpack.sv
// Assembles four little-endian bytes into one converted L/R frame and holds
// it behind a valid/ready output register.
module wav_frame_unpack
    import wav_pkg::*;
#(
    parameter int OUT_FORMAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic        i_out_ready,
    output logic [1:0]  o_phase,
    output logic [23:0] o_out_L,
    output logic [23:0] o_out_R,
    output logic        o_out_valid
);

    logic [1:0]  r_phase;
    logic [7:0]  r_l_lo;
    logic [7:0]  r_l_hi;
    logic [7:0]  r_r_lo;
    logic [23:0] r_out_L;
    logic [23:0] r_out_R;
    logic        r_out_valid;

    // Byte capture per phase; phase 3 loads the converted frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase     <= 2'd0;
            r_l_lo      <= 8'd0;
            r_l_hi      <= 8'd0;
            r_r_lo      <= 8'd0;
            r_out_L     <= 24'd0;
            r_out_R     <= 24'd0;
            r_out_valid <= 1'b0;
        end else begin
            if (i_flush) begin
                r_phase <= 2'd0;
            end else if (i_accept) begin
                case (r_phase)
                    2'd0: r_l_lo <= i_byte;
                    2'd1: r_l_hi <= i_byte;
                    2'd2: r_r_lo <= i_byte;
                    2'd3: begin
                        r_out_L <= conv_sample({r_l_hi, r_l_lo}, OUT_FORMAT);
                        r_out_R <= conv_sample({i_byte, r_r_lo}, OUT_FORMAT);
                    end
                    default: r_l_lo <= r_l_lo;
                endcase
                r_phase <= r_phase + 2'd1;
            end
            if (i_accept && !i_flush && (r_phase == 2'd3)) begin
                r_out_valid <= 1'b1;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_phase     = r_phase;
    assign o_out_L     = r_out_L;
    assign o_out_R     = r_out_R;
    assign o_out_valid = r_out_valid;

endmodule

// File: rtl/wav_reader.sv
// RIFF/WAVE byte-stream reader: checks the canonical PCM header, captures
// rate and data size, then streams stereo 16-bit frames as 24-bit samples.
module wav_reader
    import wav_pkg::*;
#(
    parameter int OUT_FORMAT = 0,
    parameter int HDR_BYTES  = WAV_HDR_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [23:0] out_L,
    output logic [23:0] out_R,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sample_rate,
    output logic [31:0] data_bytes,
    output logic        hdr_ok,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code
);

    state_e      r_state;
    logic [5:0]  r_idx;
    logic [31:0] r_remaining;
    logic [31:0] r_sample_rate;
    logic [31:0] r_data_bytes;
    logic        r_hdr_ok;
    logic        r_done;
    logic        r_err;
    err_code_e   r_err_code;

    logic        w_byte_ready;
    logic        w_accept;
    logic        w_start_go;
    logic        w_tail_end;
    logic        w_flush;
    logic        w_unpack_accept;
    logic        w_out_valid;
    logic [1:0]  w_phase;
    logic [31:0] w_size_next;
    hdr_exp_t    w_exp;

    // Input readiness; a pending frame blocks the stream for one bubble.
    always_comb begin
        w_byte_ready = 1'b0;
        case (r_state)
            ST_HDR:  w_byte_ready = 1'b1;
            ST_DATA: w_byte_ready = !w_out_valid && (r_remaining != 32'd0);
            default: w_byte_ready = 1'b0;
        endcase
    end

    assign w_accept        = byte_valid && w_byte_ready;
    assign w_start_go      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));
    assign w_exp           = hdr_expect(r_idx);
    assign w_size_next     = {byte_in, r_data_bytes[31:8]};
    assign w_unpack_accept = (r_state == ST_DATA) && w_accept;
    // Last byte lands mid-frame: the partial frame is dropped.
    assign w_tail_end      = w_unpack_accept && (r_remaining == 32'd1) && (w_phase != 2'd3);
    assign w_flush         = w_start_go || w_tail_end;

    // Main control FSM: header check, data byte counting, completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= 6'd0;
            r_remaining   <= 32'd0;
            r_sample_rate <= 32'd0;
            r_data_bytes  <= 32'd0;
            r_hdr_ok      <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state     <= ST_HDR;
                        r_idx       <= 6'd0;
                        r_remaining <= 32'd0;
                        r_hdr_ok    <= 1'b0;
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_err_code  <= ERR_NONE;
                    end
                end
                ST_HDR: begin
                    if (w_accept) begin
                        if (w_exp.chk && (byte_in != w_exp.val)) begin
                            r_state    <= ST_ERROR;
                            r_err      <= 1'b1;
                            r_err_code <= w_exp.code;
                        end else begin
                            if (r_idx[5:2] == OFF_RATE[5:2]) begin
                                r_sample_rate <= {byte_in, r_sample_rate[31:8]};
                            end
                            if (r_idx[5:2] == OFF_SIZE[5:2]) begin
                                r_data_bytes <= w_size_next;
                            end
                            if (r_idx == 6'(HDR_BYTES - 1)) begin
                                r_hdr_ok    <= 1'b1;
                                r_remaining <= w_size_next;
                                if (w_size_next == 32'd0) begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= ST_DATA;
                                end
                            end else begin
                                r_idx <= r_idx + 6'd1;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - 32'd1;
                        if (w_tail_end) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else if ((r_remaining == 32'd0) && w_out_valid && out_ready) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    wav_frame_unpack #(
        .OUT_FORMAT (OUT_FORMAT)
    ) u_unpack (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (w_flush),
        .i_accept    (w_unpack_accept),
        .i_byte      (byte_in),
        .i_out_ready (out_ready),
        .o_phase     (w_phase),
        .o_out_L     (out_L),
        .o_out_R     (out_R),
        .o_out_valid (w_out_valid)
    );

    assign byte_ready  = w_byte_ready;
    assign out_valid   = w_out_valid;
    assign sample_rate = r_sample_rate;
    assign data_bytes  = r_data_bytes;
    assign hdr_ok      = r_hdr_ok;
    assign busy        = (r_state == ST_HDR) || (r_state == ST_DATA);
    assign done        = r_done;
    assign err         = r_err;
    assign err_code    = r_err_code;

endmodule
